// File: rtl/sys_cmd_pkg.sv
// Shared opcodes, command encoding, FSM states and frame/response lengths
// for the system-control UART command initiator.
package sys_cmd_pkg;

    localparam logic [7:0] OPC_RF_WR  = 8'hAA;
    localparam logic [7:0] OPC_RF_RD  = 8'hBB;
    localparam logic [7:0] OPC_ALU_AB = 8'hCC;
    localparam logic [7:0] OPC_ALU_NO = 8'hDD;

    typedef enum logic [1:0] {
        OP_RF_WR  = 2'd0,
        OP_RF_RD  = 2'd1,
        OP_ALU_AB = 2'd2,
        OP_ALU_NO = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RECV
    } state_e;

    function automatic logic [2:0] frame_len(input cmd_op_e op);
        logic [2:0] len;
        unique case (op)
            OP_RF_WR:  len = 3'd3;
            OP_RF_RD:  len = 3'd2;
            OP_ALU_AB: len = 3'd4;
            default:   len = 3'd2;
        endcase
        return len;
    endfunction

    function automatic logic [1:0] rsp_len(input cmd_op_e op);
        logic [1:0] len;
        unique case (op)
            OP_RF_WR: len = 2'd0;
            OP_RF_RD: len = 2'd1;
            default:  len = 2'd2;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/sys_cmd_initiator_frame_builder.sv
// Combinational frame byte select from the registered command fields
// and the current byte index within the frame.
module sys_cmd_frame_builder
    import sys_cmd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
) (
    input  cmd_op_e          op_i,
    input  logic [ADDR-1:0]  addr_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       fun_i,
    input  logic [1:0]       idx_i,
    output logic [WIDTH-1:0] byte_o
);

    logic [WIDTH-1:0] addr_b;
    logic [WIDTH-1:0] fun_b;

    assign addr_b = WIDTH'(addr_i);
    assign fun_b  = WIDTH'(fun_i);

    always_comb begin
        byte_o = '0;
        unique case (op_i)
            OP_RF_WR: begin
                unique case (idx_i)
                    2'd0:    byte_o = WIDTH'(OPC_RF_WR);
                    2'd1:    byte_o = addr_b;
                    default: byte_o = a_i;
                endcase
            end
            OP_RF_RD: begin
                byte_o = (idx_i == 2'd0) ? WIDTH'(OPC_RF_RD) : addr_b;
            end
            OP_ALU_AB: begin
                unique case (idx_i)
                    2'd0:    byte_o = WIDTH'(OPC_ALU_AB);
                    2'd1:    byte_o = a_i;
                    2'd2:    byte_o = b_i;
                    default: byte_o = fun_b;
                endcase
            end
            default: begin
                byte_o = (idx_i == 2'd0) ? WIDTH'(OPC_ALU_NO) : fun_b;
            end
        endcase
    end

endmodule

// File: rtl/sys_cmd_initiator.sv
// Host-side command initiator: serializes a command frame to the UART TX
// and assembles the response from UART RX. Optional: CMD_TIMEOUT_EN.
module sys_cmd_initiator
    import sys_cmd_pkg::*;
#(
    parameter int          WIDTH          = 8,
    parameter int          ADDR           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid_in,
    output logic               cmd_ready_out,
    input  logic [1:0]         cmd_op_in,
    input  logic [ADDR-1:0]    cmd_addr_in,
    input  logic [WIDTH-1:0]   cmd_data_a_in,
    input  logic [WIDTH-1:0]   cmd_data_b_in,
    input  logic [3:0]         cmd_fun_in,
    input  logic               uart_tx_busy_in,
    output logic [WIDTH-1:0]   uart_tx_data_out,
    output logic               uart_tx_data_valid_out,
    input  logic [WIDTH-1:0]   uart_rx_data_in,
    input  logic               uart_rx_data_valid_in,
    output logic [2*WIDTH-1:0] rsp_data_out,
    output logic               rsp_valid_out,
    output logic               rsp_timeout_out
);

    state_e               state_q, state_d;
    cmd_op_e              op_q, op_d;
    logic [ADDR-1:0]      addr_q, addr_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [3:0]           fun_q, fun_d;
    logic [1:0]           idx_q, idx_d;
    logic                 rx_cnt_q, rx_cnt_d;
    logic [2*WIDTH-1:0]   rsp_q, rsp_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [WIDTH-1:0]     tx_data_q, tx_data_d;
    logic [WIDTH-1:0]     frame_byte;
    logic                 last_byte;
    logic                 last_rx;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_pulse_q, tmo_pulse_d;
`endif

    sys_cmd_frame_builder #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR)
    ) u_frame (
        .op_i   (op_q),
        .addr_i (addr_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .fun_i  (fun_q),
        .idx_i  (idx_q),
        .byte_o (frame_byte)
    );

    assign last_byte = ({1'b0, idx_q} + 3'd1) == frame_len(op_q);
    assign last_rx   = ({1'b0, rx_cnt_q} + 2'd1) == rsp_len(op_q);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        idx_d       = idx_q;
        rx_cnt_d    = rx_cnt_q;
        rsp_d       = rsp_q;
        rsp_valid_d = 1'b0;
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;
`ifdef CMD_TIMEOUT_EN
        tmo_d       = tmo_q;
        tmo_pulse_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_in) begin
                    op_d    = cmd_op_e'(cmd_op_in);
                    addr_d  = cmd_addr_in;
                    a_d     = cmd_data_a_in;
                    b_d     = cmd_data_b_in;
                    fun_d   = cmd_fun_in;
                    idx_d   = 2'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!uart_tx_busy_in) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = frame_byte;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (uart_tx_busy_in) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_tx_busy_in) begin
                    if (!last_byte) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_SEND;
                    end else if (rsp_len(op_q) == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        rx_cnt_d = 1'b0;
                        state_d  = ST_RECV;
`ifdef CMD_TIMEOUT_EN
                        tmo_d    = '0;
`endif
                    end
                end
            end
            ST_RECV: begin
                if (uart_rx_data_valid_in) begin
                    // first byte of a response also clears the upper half
                    if (!rx_cnt_q) begin
                        rsp_d = {{WIDTH{1'b0}}, uart_rx_data_in};
                    end else begin
                        rsp_d[2*WIDTH-1:WIDTH] = uart_rx_data_in;
                    end
`ifdef CMD_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (last_rx) begin
                        rsp_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        rx_cnt_d = 1'b1;
                    end
                end
`ifdef CMD_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_pulse_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_RF_WR;
            addr_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            idx_q       <= '0;
            rx_cnt_q    <= 1'b0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            idx_q       <= idx_d;
            rx_cnt_q    <= rx_cnt_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q       <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_q       <= tmo_d;
            tmo_pulse_q <= tmo_pulse_d;
        end
    end

    assign rsp_timeout_out = tmo_pulse_q;
`else
    assign rsp_timeout_out = 1'b0;
`endif

    assign cmd_ready_out          = (state_q == ST_IDLE);
    assign uart_tx_data_out       = tx_data_q;
    assign uart_tx_data_valid_out = tx_valid_q;
    assign rsp_data_out           = rsp_q;
    assign rsp_valid_out          = rsp_valid_q;

endmodule

// File: tb/tb_sys_cmd_initiator.sv
// Directed self-checking bench for sys_cmd_initiator with a frame/response
// model, a busy-modelling transmitter and a per-cycle compare process.
module tb_sys_cmd_initiator;

    localparam int WIDTH = 8;
    localparam int ADDR  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid_in = 1'b0;
    logic        cmd_ready_out;
    logic [1:0]  cmd_op_in = '0;
    logic [3:0]  cmd_addr_in = '0;
    logic [7:0]  cmd_data_a_in = '0;
    logic [7:0]  cmd_data_b_in = '0;
    logic [3:0]  cmd_fun_in = '0;
    logic        uart_tx_busy_in = 1'b0;
    logic [7:0]  uart_tx_data_out;
    logic        uart_tx_data_valid_out;
    logic [7:0]  uart_rx_data_in = '0;
    logic        uart_rx_data_valid_in = 1'b0;
    logic [15:0] rsp_data_out;
    logic        rsp_valid_out;
    logic        rsp_timeout_out;

    always #5 clk = ~clk;

    sys_cmd_initiator #(
        .WIDTH          (WIDTH),
        .ADDR           (ADDR),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .cmd_valid_in           (cmd_valid_in),
        .cmd_ready_out          (cmd_ready_out),
        .cmd_op_in              (cmd_op_in),
        .cmd_addr_in            (cmd_addr_in),
        .cmd_data_a_in          (cmd_data_a_in),
        .cmd_data_b_in          (cmd_data_b_in),
        .cmd_fun_in             (cmd_fun_in),
        .uart_tx_busy_in        (uart_tx_busy_in),
        .uart_tx_data_out       (uart_tx_data_out),
        .uart_tx_data_valid_out (uart_tx_data_valid_out),
        .uart_rx_data_in        (uart_rx_data_in),
        .uart_rx_data_valid_in  (uart_rx_data_valid_in),
        .rsp_data_out           (rsp_data_out),
        .rsp_valid_out          (rsp_valid_out),
        .rsp_timeout_out        (rsp_timeout_out)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]  txq[$];
    logic [15:0] rspq[$];
    bit stuck = 1'b0;
    int busy_len = 10;
    bit tmo_expected = 1'b0;
    int tmo_seen = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // expected frame from the command, by the protocol's byte layout
    function automatic void push_frame(input logic [1:0] op,
                                       input logic [3:0] addr,
                                       input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [3:0] fun);
        case (op)
            2'd0: begin
                txq.push_back(8'hAA);
                txq.push_back({4'h0, addr});
                txq.push_back(a);
            end
            2'd1: begin
                txq.push_back(8'hBB);
                txq.push_back({4'h0, addr});
            end
            2'd2: begin
                txq.push_back(8'hCC);
                txq.push_back(a);
                txq.push_back(b);
                txq.push_back({4'h0, fun});
            end
            default: begin
                txq.push_back(8'hDD);
                txq.push_back({4'h0, fun});
            end
        endcase
    endfunction

    // transmitter model: busy rises right after a strobe, lasts busy_len
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) cnt = 0;
            else if (uart_tx_data_valid_out) cnt = busy_len;
            else if (cnt > 0) cnt--;
            uart_tx_busy_in = stuck || (cnt > 0);
        end
    end

    // compare process
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (uart_tx_data_valid_out) begin
                    if (txq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected got %h want none",
                                 uart_tx_data_out);
                    end else begin
                        chk("tx_byte", uart_tx_data_out, txq.pop_front());
                    end
                end
                if (rsp_valid_out) begin
                    chk("rsp_ready", cmd_ready_out, 1);
                    if (rspq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected got %h want none",
                                 rsp_data_out);
                    end else begin
                        chk("rsp_data", rsp_data_out, rspq.pop_front());
                    end
                end
                if (rsp_timeout_out) begin
                    tmo_seen++;
                    checks++;
                    if (!tmo_expected) begin
                        errors++;
                        $display("FAIL tmo_unexpected got 1 want 0");
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (!cmd_ready_out && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready_out) begin
            checks++;
            errors++;
            $display("FAIL %s ready timeout got 0 want 1", name);
        end
    endtask

    task automatic wait_sent(input string name);
        int t;
        t = 0;
        while ((txq.size() != 0 || uart_tx_busy_in) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (txq.size() != 0 || uart_tx_busy_in) begin
            checks++;
            errors++;
            $display("FAIL %s frame timeout got %0d want 0", name, txq.size());
        end
        cyc(2);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] addr,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] fun, input bit chk_first);
        wait_ready("pre_cmd");
        push_frame(op, addr, a, b, fun);
        cmd_op_in     = op;
        cmd_addr_in   = addr;
        cmd_data_a_in = a;
        cmd_data_b_in = b;
        cmd_fun_in    = fun;
        cmd_valid_in  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_in  = 1'b0;
        cmd_op_in     = 2'($urandom);
        cmd_addr_in   = 4'($urandom);
        cmd_data_a_in = 8'($urandom);
        cmd_data_b_in = 8'($urandom);
        cmd_fun_in    = 4'($urandom);
        chk("ready_low", cmd_ready_out, 0);
        if (chk_first) begin
            @(posedge clk);
            #1;
            chk("first_strobe", uart_tx_data_valid_out, 1);
        end
    endtask

    task automatic do_rx(input logic [1:0] op, input logic [7:0] b0,
                         input logic [7:0] b1);
        int n;
        n = (op == 2'd1) ? 1 : 2;
        rspq.push_back((op == 2'd1) ? {8'h00, b0} : {b1, b0});
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            uart_rx_data_in       = (i == 0) ? b0 : b1;
            uart_rx_data_valid_in = 1'b1;
            @(negedge clk);
            uart_rx_data_valid_in = 1'b0;
            uart_rx_data_in       = 8'($urandom);
            cyc(2);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_ready"}, cmd_ready_out, 1);
        chk({name, "_txv"}, uart_tx_data_valid_out, 0);
        chk({name, "_txd"}, uart_tx_data_out, 0);
        chk({name, "_rsp"}, rsp_data_out, 0);
        chk({name, "_rspv"}, rsp_valid_out, 0);
        chk({name, "_tmo"}, rsp_timeout_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset_n = 1'b0;
        cyc(3);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        cyc(2);

        // RF write addr 3 data 0x5A
        send_cmd(2'd0, 4'd3, 8'h5A, 8'h00, 4'd0, 1'b1);
        wait_ready("wr");
        chk("wr_all_sent", txq.size(), 0);
        chk("wr_busy_fallen", uart_tx_busy_in, 0);
        chk("wr_txd_hold", uart_tx_data_out, 8'h5A);
        cyc(3);

        // RF read addr 7 -> 0x3C
        send_cmd(2'd1, 4'd7, 8'h00, 8'h00, 4'd0, 1'b1);
        wait_sent("rd");
        do_rx(2'd1, 8'h3C, 8'h00);
        wait_ready("rd");
        chk("rd_rsp_lit", rsp_data_out, 16'h003C);
        chk("rd_txd_hold", uart_tx_data_out, 8'h07);

        // ALU A=0x12 B=0x34 fun 2 -> 0x0046
        send_cmd(2'd2, 4'd0, 8'h12, 8'h34, 4'd2, 1'b0);
        wait_sent("alu");
        do_rx(2'd2, 8'h46, 8'h00);
        wait_ready("alu");
        chk("alu_rsp_lit", rsp_data_out, 16'h0046);

        // response holds across a write with no response
        send_cmd(2'd0, 4'd1, 8'hC3, 8'h00, 4'd0, 1'b0);
        wait_ready("wr2");
        chk("rsp_stable", rsp_data_out, 16'h0046);

        // rx byte while idle is dropped
        @(negedge clk);
        uart_rx_data_in       = 8'hEE;
        uart_rx_data_valid_in = 1'b1;
        @(negedge clk);
        uart_rx_data_valid_in = 1'b0;
        cyc(3);
        chk("rx_drop", rsp_data_out, 16'h0046);

        // busy stuck high before the first byte
        stuck = 1'b1;
        cyc(2);
        send_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'd9, 1'b0);
        cyc(50);
        chk("stuck_hold", txq.size(), 2);
        chk("stuck_no_strobe", uart_tx_data_valid_out, 0);
        stuck = 1'b0;
        wait_sent("aluno");
        do_rx(2'd3, 8'h21, 8'h43);
        wait_ready("aluno");
        chk("aluno_rsp_lit", rsp_data_out, 16'h4321);

`ifdef CMD_TIMEOUT_EN
        tmo_expected = 1'b1;
        send_cmd(2'd1, 4'd2, 8'h00, 8'h00, 4'd0, 1'b0);
        wait_sent("tmo");
        t = 0;
        while (tmo_seen == 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_seen", tmo_seen, 1);
        chk("tmo_latency", (t >= 90 && t <= 105), 1);
        chk("tmo_ready", cmd_ready_out, 1);
        chk("tmo_rsp_keep", rsp_data_out, 16'h4321);
        cyc(2);
        tmo_expected = 1'b0;
        chk("tmo_single", tmo_seen, 1);
`else
        send_cmd(2'd1, 4'd2, 8'h00, 8'h00, 4'd0, 1'b0);
        wait_sent("notmo");
        cyc(200);
        chk("notmo_waiting", cmd_ready_out, 0);
        chk("notmo_none", tmo_seen, 0);
        do_rx(2'd1, 8'h77, 8'h00);
        wait_ready("notmo");
        chk("notmo_rsp_lit", rsp_data_out, 16'h0077);
`endif

        // reset during second byte of an ALU frame
        send_cmd(2'd2, 4'd0, 8'h12, 8'h34, 4'd5, 1'b0);
        t = 0;
        while (txq.size() > 2 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("mid_reached", txq.size(), 2);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        txq.delete();
        cyc(3);
        reset_n = 1'b1;
        cyc(2);

        send_cmd(2'd1, 4'd7, 8'h00, 8'h00, 4'd0, 1'b1);
        wait_sent("post_rst");
        do_rx(2'd1, 8'h5D, 8'h00);
        wait_ready("post_rst");
        chk("post_rst_rsp_lit", rsp_data_out, 16'h005D);

        cyc(5);
        chk("txq_drained", txq.size(), 0);
        chk("rspq_drained", rspq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
